// File: rtl/demux_dispatcher.sv
// Registered 1-to-2 stream dispatcher: each output has its own FIFO so a stalled sink never blocks the other.
// Optional per-output push counters (o1_cnt/o2_cnt) enabled by DEMUX_DISPATCHER_STATS_EN.

module demux_dispatcher_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0]               cnt;
    logic [WIDTH-1:0]            head_q;
    logic                        pop;

    assign rd_nxt   = rd_ptr + 1'b1;
    assign pop      = rd_ready && (cnt != '0);
    assign full     = (cnt == CW'(DEPTH));
    assign rd_valid = (cnt != '0);
    assign rd_data  = head_q;

    // Head is kept in its own register so an empty FIFO still shows the last popped beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (push && (cnt == '0 || (pop && cnt == CW'(1))))
                head_q <= wr_data;
            else if (pop && cnt > CW'(1))
                head_q <= mem[rd_nxt];
        end
    end
endmodule

module demux_dispatcher #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] o1_data,
    output logic             o1_valid,
    input  logic             o1_ready,
    output logic [WIDTH-1:0] o2_data,
    output logic             o2_valid,
    input  logic             o2_ready,
`ifdef DEMUX_DISPATCHER_STATS_EN
    output logic [15:0]      o1_cnt,
    output logic [15:0]      o2_cnt,
`endif
    output logic             busy
);
    // Lane 0 feeds output 1 (sel=1), lane 1 feeds output 2 (sel=0).
    logic [1:0]            push, rd_ready, valid, full;
    logic [1:0][WIDTH-1:0] data;
    logic                  accept;

    assign in_ready    = in_sel ? ~full[0] : ~full[1];
    assign accept      = in_valid && in_ready;
    assign push        = {accept && !in_sel, accept && in_sel};
    assign rd_ready    = {o2_ready, o1_ready};

    genvar g;
    for (g = 0; g < 2; g++) begin : g_fifo
        demux_dispatcher_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[g]),
            .wr_data  (in_data),
            .rd_ready (rd_ready[g]),
            .rd_data  (data[g]),
            .rd_valid (valid[g]),
            .full     (full[g])
        );
    end

    assign o1_data  = data[0];
    assign o1_valid = valid[0];
    assign o2_data  = data[1];
    assign o2_valid = valid[1];
    assign busy     = |valid;

`ifdef DEMUX_DISPATCHER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o1_cnt <= '0;
            o2_cnt <= '0;
        end else begin
            if (push[0]) o1_cnt <= o1_cnt + 16'd1;
            if (push[1]) o2_cnt <= o2_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed bench for demux_dispatcher: reset, routing, backpressure, full+pop, wrap stream, mid-op reset.
// Build with DEMUX_DISPATCHER_STATS_EN to also check the push counters.

module tb_demux_dispatcher;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_sel, in_ready;
    logic [7:0] o1_data, o2_data;
    logic       o1_valid, o2_valid, o1_ready, o2_ready, busy;
`ifdef DEMUX_DISPATCHER_STATS_EN
    logic [15:0] o1_cnt, o2_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_dispatcher #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_ready (in_ready),
        .o1_data  (o1_data),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .o2_data  (o2_data),
        .o2_valid (o2_valid),
        .o2_ready (o2_ready),
`ifdef DEMUX_DISPATCHER_STATS_EN
        .o1_cnt   (o1_cnt),
        .o2_cnt   (o2_cnt),
`endif
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    logic [7:0] q1[$], q2[$];
    int         sent1, sent2, rcv1, rcv2;
    logic       m_rdy, acc, pop1, pop2;

    initial begin
        // Reset with random inputs
        rst_n    = 1'b0;
        in_data  = 8'($urandom);
        in_valid = 1'b1;
        in_sel   = 1'($urandom);
        o1_ready = 1'($urandom);
        o2_ready = 1'($urandom);
        tick();
        in_data  = 8'($urandom);
        tick();
        #1;
        chk("rst_o1_valid", o1_valid, 0);
        chk("rst_o2_valid", o2_valid, 0);
        chk("rst_busy",     busy,     0);
        chk("rst_o1_data",  o1_data,  0);
        chk("rst_o2_data",  o2_data,  0);
        chk("rst_in_ready", in_ready, 1);
`ifdef DEMUX_DISPATCHER_STATS_EN
        chk("rst_o1_cnt", o1_cnt, 0);
        chk("rst_o2_cnt", o2_cnt, 0);
`endif

        // Route one beat to each output
        rst_n = 1'b1; o1_ready = 1'b1; o2_ready = 1'b1;
        drive(1'b1, 1'b1, 8'hA5);
        chk("route_no_bypass", o1_valid, 0);
        tick();
        chk("route_o1_valid", o1_valid, 1);
        chk("route_o1_data",  o1_data,  8'hA5);
        chk("route_o2_idle",  o2_valid, 0);
        drive(1'b1, 1'b0, 8'h5A);
        tick();
        chk("route_o1_once",  o1_valid, 0);
        chk("route_o1_hold",  o1_data,  8'hA5);
        chk("route_o2_valid", o2_valid, 1);
        chk("route_o2_data",  o2_data,  8'h5A);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        chk("route_o2_once",  o2_valid, 0);
        chk("route_busy",     busy,     0);
`ifdef DEMUX_DISPATCHER_STATS_EN
        chk("route_o1_cnt", o1_cnt, 1);
        chk("route_o2_cnt", o2_cnt, 1);
`endif

        // Fill FIFO1 with sinks stalled
        o1_ready = 1'b0; o2_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 8'(i));
            chk("full_rdy_fill", in_ready, 1);
            tick();
        end
        drive(1'b1, 1'b1, 8'd5);
        chk("full_rdy_after4", in_ready, 0);
        drive(1'b1, 1'b0, 8'h77);
        chk("full_other_rdy", in_ready, 1);
        tick();
        chk("full_o2_valid", o2_valid, 1);
        chk("full_o2_data",  o2_data,  8'h77);
        drive(1'b1, 1'b1, 8'd5);
        tick();
        chk("full_stall_head", o1_data, 8'd1);
        // Full + pop in the same cycle: push refused now, accepted next
        o1_ready = 1'b1;
        #1;
        chk("fullpop_refused", in_ready, 0);
        tick();
        chk("fullpop_head2", o1_data, 8'd2);
        chk("fullpop_rdy",   in_ready, 1);
        tick();
        drive(1'b0, 1'b1, 8'd0);
        chk("drain_head3", o1_data, 8'd3);
        tick();
        chk("drain_head4", o1_data, 8'd4);
        tick();
        chk("drain_head5", o1_data, 8'd5);
        chk("drain_valid5", o1_valid, 1);
        tick();
        chk("drain_empty", o1_valid, 0);
        chk("drain_hold",  o1_data,  8'd5);
        chk("drain_busy",  busy,     1);
        o2_ready = 1'b1;
        tick();
        chk("drain_o2_empty", o2_valid, 0);
        chk("drain_idle",     busy,     0);

        // Wrap: 20 beats per output, random sink readiness, model queues
        sent1 = 0; sent2 = 0; rcv1 = 0; rcv2 = 0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && (rcv1 < 20 || rcv2 < 20); cyc++) begin
            if (!in_valid && (sent1 < 20 || sent2 < 20)) begin
                if (sent1 >= 20)      in_sel = 1'b0;
                else if (sent2 >= 20) in_sel = 1'b1;
                else                  in_sel = 1'($urandom);
                in_data  = in_sel ? 8'(8'h10 + sent1) : 8'(8'h80 + sent2);
                in_valid = 1'b1;
            end
            o1_ready = 1'($urandom);
            o2_ready = 1'($urandom);
            #1;
            m_rdy = in_sel ? (q1.size() < 4) : (q2.size() < 4);
            chk("wrap_in_ready", in_ready, m_rdy);
            chk("wrap_o1_valid", o1_valid, q1.size() > 0);
            chk("wrap_o2_valid", o2_valid, q2.size() > 0);
            if (q1.size() > 0) chk("wrap_o1_data", o1_data, q1[0]);
            if (q2.size() > 0) chk("wrap_o2_data", o2_data, q2[0]);
            acc  = in_valid && m_rdy;
            pop1 = (q1.size() > 0) && o1_ready;
            pop2 = (q2.size() > 0) && o2_ready;
            tick();
            if (pop1) begin void'(q1.pop_front()); rcv1++; end
            if (pop2) begin void'(q2.pop_front()); rcv2++; end
            if (acc) begin
                if (in_sel) begin q1.push_back(in_data); sent1++; end
                else        begin q2.push_back(in_data); sent2++; end
                in_valid = 1'b0;
            end
        end
        chk("wrap_rcv1", rcv1, 20);
        chk("wrap_rcv2", rcv2, 20);
        in_valid = 1'b0;
        tick();
        chk("wrap_idle", busy, 0);

        // Mid-operation reset flushes queued beats
        o1_ready = 1'b0; o2_ready = 1'b0;
        drive(1'b1, 1'b1, 8'hC1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'(8'hE0 + i));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        chk("mid_o2_before", o2_valid, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_o2_valid", o2_valid, 0);
        chk("mid_o1_valid", o1_valid, 0);
        chk("mid_o2_data",  o2_data,  0);
        chk("mid_busy",     busy,     0);
`ifdef DEMUX_DISPATCHER_STATS_EN
        chk("mid_o1_cnt", o1_cnt, 0);
        chk("mid_o2_cnt", o2_cnt, 0);
`endif
        rst_n = 1'b1; o1_ready = 1'b1; o2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_stale", o2_valid, 0);
        end
        chk("mid_in_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
